implication_queue: RTL and testbench
====================================

// Module: implication_queue
// PURPOSE
//  Downstream of sub_clause_evaluator in the BCP datapath. Accepts one implication per cycle
//  (unit_clause, implied_variable, new_val) and buffers it in a FIFO. Drops duplicates of pending
//  implications. Detects conflicts: same variable implied with opposite polarity.
//  Feeds the assignment/decision stage through a valid/ready handshake.
// PARAMETERS
//  NUM_VARIABLE   128  number of SAT variables; VARIABLE_INDEX = $clog2(NUM_VARIABLE)-1
//  DEPTH          8    FIFO entries; power of two, >= 2; CNT_W = $clog2(DEPTH)+1
// PORTS
//  clock            in   1                   single clock, rising edge
//  reset            in   1                   synchronous, active-high
//  flush            in   1                   discard all entries and clear conflict (backtrack)
//  in_valid         in   1                   evaluator result valid this cycle
//  in_unit_clause   in   1                   evaluator unit_clause; push only when 1
//  in_var           in   VARIABLE_INDEX+1    evaluator implied_variable
//  in_val           in   1                   evaluator new_val
//  in_ready         out  1                   = !full && !conflict
//  out_valid        out  1                   head entry available
//  out_var          out  VARIABLE_INDEX+1    head variable
//  out_val          out  1                   head value
//  out_ready        in   1                   consumer takes head when out_valid && out_ready
//  conflict         out  1                   sticky: opposite-polarity implication seen
//  conflict_var     out  VARIABLE_INDEX+1    variable that caused the conflict
//  count            out  CNT_W               pending entries
// BEHAVIOUR
//  - Reset: empty; out_valid=0, out_var=0, out_val=0, conflict=0, conflict_var=0, count=0, in_ready=1.
//  - Accept: acc = in_valid && in_unit_clause && in_ready. in_valid with in_unit_clause=0 is ignored.
//  - Match: compare in_var against every valid entry present at the start of the cycle.
//    This includes the head, even if it is popped in the same cycle.
//  - Same var, same val: accepted and dropped; no push, count unchanged by the push.
//  - Same var, opposite val: no push. Next edge: conflict<=1, conflict_var<=in_var.
//  - No match: write at tail; entry visible at out_* from the next cycle (1-cycle latency).
//  - Pop: out_valid && out_ready advances the head. Pop and push may occur in the same cycle;
//    count then holds.
//  - Full: in_ready=0. There is no same-cycle bypass from a pop, so a full queue with a pop
//    still refuses input.
//  - out_valid = !empty && !conflict. Entries are frozen while conflict=1.
//  - flush has priority over push, pop and conflict capture. Next edge: empty, count=0,
//    conflict=0, conflict_var=0.
//  - Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. The count/full/empty logic
//    handles tail==head both when full and when empty.
//  - Holding in_valid with in_ready=0 has no effect. The producer holds its inputs until
//    in_ready=1.
// CONFIGURATION
//  - IMPL_QUEUE_STATS_EN defined: adds outputs stat_push, stat_dup, stat_conf (16 bits each,
//    saturating). They count pushes, dropped duplicates and conflict captures.
//    Cleared by reset only, not by flush.
//  - IMPL_QUEUE_STATS_EN undefined: these ports and counters do not exist. Core behaviour is identical.
// TESTING
//  - Reset then idle: count=0, out_valid=0, in_ready=1, conflict=0.
//  - Push (5,1),(9,0),(12,1), out_ready=0: count=3. Raise out_ready: pops in order 5/1, 9/0, 12/1.
//    Each entry is visible one cycle after its push.
//  - Push (7,1) twice: count=1 and one entry pops. Then push (7,0) while (7,1) is pending:
//    conflict=1, conflict_var=7 next cycle, out_valid=0, in_ready=0. Flush: all cleared next cycle.
//  - Fill 8 distinct vars: in_ready=0. Push and pop the same cycle while full: input refused,
//    count=8. Pop once: in_ready=1. Push then pop 20 more entries: wrap-around preserves order.
//  - In_unit_clause=0 with in_valid=1: no push. Flush and push in the same cycle: queue empty
//    afterwards.
//  - With IMPL_QUEUE_STATS_EN: the above sequences give stat_push, stat_dup and stat_conf
//    values that match the scoreboard.

Source files
------------

// File: rtl/implication_queue.sv
// implication_queue: buffers implications from the clause evaluator for the
// assignment/decision stage. It drops duplicates of pending implications and
// raises a sticky conflict when a pending variable is implied with the
// opposite polarity.
// Optional feature macro: IMPL_QUEUE_STATS_EN adds saturating 16-bit event
// counters (stat_push, stat_dup, stat_conf), cleared only by reset.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. On the input side, in_valid with in_unit_clause=0 is ignored.
// On the output side, the head is consumed when out_valid && out_ready.
// in_ready depends only on registered state; it never depends on out_ready.
module implication_queue #(
    parameter int NUM_VARIABLE = 128,
    parameter int DEPTH        = 8,
    localparam int VW          = $clog2(NUM_VARIABLE),
    localparam int PW          = $clog2(DEPTH),
    localparam int CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_unit_clause,
    input  logic [VW-1:0]    in_var,
    input  logic             in_val,
    output logic             in_ready,
    output logic             out_valid,
    output logic [VW-1:0]    out_var,
    output logic             out_val,
    input  logic             out_ready,
    output logic             conflict,
    output logic [VW-1:0]    conflict_var,
    output logic [CNT_W-1:0] count
`ifdef IMPL_QUEUE_STATS_EN
    ,
    output logic [15:0]      stat_push,
    output logic [15:0]      stat_dup,
    output logic [15:0]      stat_conf
`endif
);

    logic [VW-1:0]    var_mem [DEPTH];
    logic             val_mem [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             conf_q, conf_d;
    logic [VW-1:0]    conf_var_q, conf_var_d;

    logic             full, empty;
    logic             acc, match_any, match_val;
    logic             push, pop, dup_drop, conf_cap;
    logic [PW-1:0]    offs;

    // Occupancy lives in the counter, so tail==head is unambiguous.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full && !conf_q;
    assign out_valid = !empty && !conf_q;
    assign out_var   = out_valid ? var_mem[head_q] : '0;
    assign out_val   = out_valid ? val_mem[head_q] : 1'b0;
    assign conflict     = conf_q;
    assign conflict_var = conf_var_q;
    assign count        = count_q;

    // Search every entry occupied at the start of the cycle, including a head being popped.
    always_comb begin
        match_any = 1'b0;
        match_val = 1'b0;
        offs      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - head_q;
            if (({1'b0, offs} < count_q) && (var_mem[i] == in_var)) begin
                match_any = 1'b1;
                match_val = val_mem[i];
            end
        end
    end

    // Classify the accepted implication; flush overrides every queue action.
    always_comb begin
        acc      = in_valid && in_unit_clause && in_ready;
        push     = acc && !match_any && !flush;
        dup_drop = acc && match_any && (match_val == in_val) && !flush;
        conf_cap = acc && match_any && (match_val != in_val) && !flush;
        pop      = out_valid && out_ready && !flush;
    end

    // Next-state for pointers, occupancy and conflict capture.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        conf_d     = conf_q;
        conf_var_d = conf_var_q;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            conf_d     = 1'b0;
            conf_var_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (!push && pop) count_d = count_q - CNT_W'(1);
            if (conf_cap) begin
                conf_d     = 1'b1;
                conf_var_d = in_var;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            conf_q     <= 1'b0;
            conf_var_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            conf_q     <= conf_d;
            conf_var_q <= conf_var_d;
        end
    end

    // Entry storage; contents are only meaningful inside the occupied window.
    always_ff @(posedge clock) begin
        if (push) begin
            var_mem[tail_q] <= in_var;
            val_mem[tail_q] <= in_val;
        end
    end

`ifdef IMPL_QUEUE_STATS_EN
    logic [15:0] stat_push_q, stat_dup_q, stat_conf_q;

    assign stat_push = stat_push_q;
    assign stat_dup  = stat_dup_q;
    assign stat_conf = stat_conf_q;

    // Saturating event counters; flush does not clear them.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_push_q <= '0;
            stat_dup_q  <= '0;
            stat_conf_q <= '0;
        end else begin
            if (push && stat_push_q != 16'hFFFF)     stat_push_q <= stat_push_q + 16'd1;
            if (dup_drop && stat_dup_q != 16'hFFFF)  stat_dup_q  <= stat_dup_q + 16'd1;
            if (conf_cap && stat_conf_q != 16'hFFFF) stat_conf_q <= stat_conf_q + 16'd1;
        end
    end
`else
    logic unused_dup;
    assign unused_dup = dup_drop;
`endif

endmodule

// File: tb/tb_implication_queue.sv
// Testbench for implication_queue: directed vector table, hand-written
// full/wrap sequences and randomized traffic against a queue-based model.
module tb_implication_queue;

    localparam int DEPTH = 8;
    localparam int VW    = 7;
    localparam int CW    = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_unit_clause = 1'b0;
    logic [VW-1:0] in_var = '0;
    logic          in_val = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [VW-1:0] out_var;
    logic          out_val;
    logic          out_ready = 1'b0;
    logic          conflict;
    logic [VW-1:0] conflict_var;
    logic [CW-1:0] count;
`ifdef IMPL_QUEUE_STATS_EN
    logic [15:0]   stat_push, stat_dup, stat_conf;
`endif

    implication_queue #(.NUM_VARIABLE(128), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_unit_clause(in_unit_clause),
        .in_var(in_var), .in_val(in_val), .in_ready(in_ready),
        .out_valid(out_valid), .out_var(out_var), .out_val(out_val),
        .out_ready(out_ready), .conflict(conflict),
        .conflict_var(conflict_var), .count(count)
`ifdef IMPL_QUEUE_STATS_EN
        , .stat_push(stat_push), .stat_dup(stat_dup), .stat_conf(stat_conf)
`endif
    );

    // Clock
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: pending entries as {var, val}, oldest first.
    logic [VW:0]   exp_q[$];
    logic          m_cf = 1'b0;
    logic [VW-1:0] m_cv = '0;
    int            m_push = 0, m_dup = 0, m_conf = 0;

    // Outputs sampled during the most recent step.
    int   s_cnt;
    logic s_ov, s_oval, s_ir, s_cf;
    logic [VW-1:0] s_ovar, s_cv;

    typedef struct {
        logic fl, iv, uc; logic [VW-1:0] vr; logic vl, ordy;
        int e_cnt; logic e_ov; logic [VW-1:0] e_ovar; logic e_oval, e_ir, e_cf;
        logic [VW-1:0] e_cv;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t row(input logic fl, iv, uc, input int vr, input logic vl, ordy,
                                 input int cnt, input logic ov, input int ovar,
                                 input logic oval, ir, cf, input int cv);
        vec_t r;
        r.fl = fl; r.iv = iv; r.uc = uc; r.vr = VW'(vr); r.vl = vl; r.ordy = ordy;
        r.e_cnt = cnt; r.e_ov = ov; r.e_ovar = VW'(ovar); r.e_oval = oval;
        r.e_ir = ir; r.e_cf = cf; r.e_cv = VW'(cv);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle, compare outputs to the model before the edge, advance the model.
    task automatic step(input logic fl, iv, uc, input int vr, input logic vl, ordy);
        logic          ir, ov, acc;
        logic [VW-1:0] hv;
        logic          hb;
        int            hit;
        flush = fl; in_valid = iv; in_unit_clause = uc;
        in_var = VW'(vr); in_val = vl; out_ready = ordy;
        @(negedge clock);
        ir = (exp_q.size() < DEPTH) && !m_cf;
        ov = (exp_q.size() > 0) && !m_cf;
        hv = ov ? exp_q[0][VW:1] : '0;
        hb = ov ? exp_q[0][0] : 1'b0;
        s_cnt = int'(count); s_ov = out_valid; s_ovar = out_var; s_oval = out_val;
        s_ir = in_ready; s_cf = conflict; s_cv = conflict_var;
        chk("count", int'(count), exp_q.size());
        chk("out_valid", int'(out_valid), int'(ov));
        chk("out_var", int'(out_var), int'(hv));
        chk("out_val", int'(out_val), int'(hb));
        chk("in_ready", int'(in_ready), int'(ir));
        chk("conflict", int'(conflict), int'(m_cf));
        chk("conflict_var", int'(conflict_var), int'(m_cv));
        if (fl) begin
            exp_q.delete();
            m_cf = 1'b0;
            m_cv = '0;
        end else begin
            acc = iv && uc && ir;
            hit = -1;
            if (acc)
                foreach (exp_q[k]) if (exp_q[k][VW:1] == VW'(vr)) hit = k;
            if (acc) begin
                if (hit < 0) begin
                    exp_q.push_back({VW'(vr), vl});
                    m_push++;
                end else if (exp_q[hit][0] == vl) begin
                    m_dup++;
                end else begin
                    m_cf = 1'b1;
                    m_cv = VW'(vr);
                    m_conf++;
                end
            end
            if (ov && ordy) void'(exp_q.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef IMPL_QUEUE_STATS_EN
        chk({tag, "_stat_push"}, int'(stat_push), (m_push > 65535) ? 65535 : m_push);
        chk({tag, "_stat_dup"},  int'(stat_dup),  (m_dup  > 65535) ? 65535 : m_dup);
        chk({tag, "_stat_conf"}, int'(stat_conf), (m_conf > 65535) ? 65535 : m_conf);
`else
        checks += 0;
        if (tag.len() == 0) $display("stats phase");
`endif
    endtask

    initial begin
        //              fl iv uc vr vl or | cnt ov ovar oval ir cf cv
        tbl[0]  = row(0, 0, 0, 0,  0, 0,   0, 0, 0,  0, 1, 0, 0);
        tbl[1]  = row(0, 1, 1, 5,  1, 0,   0, 0, 0,  0, 1, 0, 0);
        tbl[2]  = row(0, 1, 1, 9,  0, 0,   1, 1, 5,  1, 1, 0, 0);
        tbl[3]  = row(0, 1, 1, 12, 1, 0,   2, 1, 5,  1, 1, 0, 0);
        tbl[4]  = row(0, 0, 0, 0,  0, 1,   3, 1, 5,  1, 1, 0, 0);
        tbl[5]  = row(0, 0, 0, 0,  0, 1,   2, 1, 9,  0, 1, 0, 0);
        tbl[6]  = row(0, 0, 0, 0,  0, 1,   1, 1, 12, 1, 1, 0, 0);
        tbl[7]  = row(0, 0, 0, 0,  0, 0,   0, 0, 0,  0, 1, 0, 0);
        tbl[8]  = row(0, 1, 1, 7,  1, 0,   0, 0, 0,  0, 1, 0, 0);
        tbl[9]  = row(0, 1, 1, 7,  1, 0,   1, 1, 7,  1, 1, 0, 0);
        tbl[10] = row(0, 0, 0, 0,  0, 0,   1, 1, 7,  1, 1, 0, 0);
        tbl[11] = row(0, 1, 1, 7,  0, 0,   1, 1, 7,  1, 1, 0, 0);
        tbl[12] = row(0, 0, 0, 0,  0, 1,   1, 0, 0,  0, 0, 1, 7);
        tbl[13] = row(1, 0, 0, 0,  0, 1,   1, 0, 0,  0, 0, 1, 7);
        tbl[14] = row(0, 0, 0, 0,  0, 0,   0, 0, 0,  0, 1, 0, 0);
        tbl[15] = row(0, 1, 0, 3,  1, 0,   0, 0, 0,  0, 1, 0, 0);
        tbl[16] = row(0, 0, 0, 0,  0, 0,   0, 0, 0,  0, 1, 0, 0);
        tbl[17] = row(1, 1, 1, 4,  1, 0,   0, 0, 0,  0, 1, 0, 0);
        tbl[18] = row(0, 0, 0, 0,  0, 0,   0, 0, 0,  0, 1, 0, 0);

        // Reset
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Directed vector table
        foreach (tbl[i]) begin
            step(tbl[i].fl, tbl[i].iv, tbl[i].uc, int'(tbl[i].vr), tbl[i].vl, tbl[i].ordy);
            chk($sformatf("tbl%0d_count", i), s_cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_out_valid", i), int'(s_ov), int'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_out_var", i), int'(s_ovar), int'(tbl[i].e_ovar));
            chk($sformatf("tbl%0d_out_val", i), int'(s_oval), int'(tbl[i].e_oval));
            chk($sformatf("tbl%0d_in_ready", i), int'(s_ir), int'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_conflict", i), int'(s_cf), int'(tbl[i].e_cf));
            chk($sformatf("tbl%0d_conflict_var", i), int'(s_cv), int'(tbl[i].e_cv));
        end
        chk_stats("table");
`ifdef IMPL_QUEUE_STATS_EN
        chk("table_push_const", int'(stat_push), 4);
        chk("table_dup_const", int'(stat_dup), 1);
        chk("table_conf_const", int'(stat_conf), 1);
`endif

        // Fill to full
        for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 20 + i, i[0], 0);
        step(0, 0, 0, 0, 0, 0);
        chk("full_in_ready", int'(s_ir), 0);
        chk("full_count", s_cnt, 8);
        // Push and pop in the same cycle while full: input refused
        step(0, 1, 1, 30, 1, 1);
        chk("full_pushpop_count", s_cnt, 8);
        chk("full_pushpop_in_ready", int'(s_ir), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("after_pop_in_ready", int'(s_ir), 1);
        chk("after_pop_count", s_cnt, 7);
        // Streaming through the wrap point
        for (int i = 0; i < 20; i++) step(0, 1, 1, 40 + i, i[1], 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("drained_count", s_cnt, 0);
        chk_stats("wrap");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int vr;
            vr = int'($urandom_range(0, 11));
            step($urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) != 0,
                 vr,
                 vr[0] ^ ($urandom_range(0, 15) == 0),
                 $urandom_range(0, 2) != 0);
        end
        chk_stats("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
